sdram_wr_burst: RTL and testbench

Parametrised SDRAM write engine, next generation of the single-bank fixed-pattern writer. Takes a start address (bank/row/column) and a length in bursts, then streams data from a show-ahead write FIFO. Handles row crossing, refresh pre-emption with resume, and tRCD/tRP/tWR timing. Sits under the SDRAM top arbiter beside the refresh and read engines and shares the command bus with them.

---
 rtl/sdram_pkg.sv | 30 +++
 rtl/sdram_wr_addr_gen.sv | 55 +++++
 rtl/sdram_wr_burst.sv | 217 +++++++++++++++++++++
 tb/tb_sdram_wr_burst.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command codes, address constants and write-engine states
package sdram_pkg;

   // SDRAM commands as {CS_n, RAS_n, CAS_n, WE_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;

   // A10 selects precharge-all on PRE and must be low on WR (no auto-precharge)
   localparam int A10_BIT = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACT,
      ST_WR,
      ST_RECOV,
      ST_PRE
   } wr_state_t;

   // Where the engine goes once the precharge window has elapsed
   typedef enum logic [1:0] {
      EXIT_IDLE,
      EXIT_REQ,
      EXIT_ACT
   } wr_exit_t;

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// rtl/sdram_wr_addr_gen.sv - bank/row/column/burst-count tracking for the write engine
module sdram_wr_addr_gen
   import sdram_pkg::*;
#(
   parameter int ROW_W  = 13,
   parameter int COL_W  = 9,
   parameter int BANK_W = 2,
   parameter int BL     = 4,
   parameter int LEN_W  = 16
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              load,
   input  logic [BANK_W-1:0] ld_bank,
   input  logic [ROW_W-1:0]  ld_row,
   input  logic [COL_W-1:0]  ld_col,
   input  logic [LEN_W-1:0]  ld_len,
   input  logic              step,
   output logic [BANK_W-1:0] bank,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic              col_wrap,
   output logic              last_burst
);

   logic [LEN_W-1:0] remaining;
   logic [COL_W:0]   col_sum;

   // One extra bit catches the column running off the end of the row
   assign col_sum    = {1'b0, col} + (COL_W+1)'(BL);
   assign col_wrap   = col_sum[COL_W];
   assign last_burst = (remaining == LEN_W'(1));

   // Load on trigger, advance one burst per step; row carries on column wrap and stays in bank
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         bank      <= '0;
         row       <= '0;
         col       <= '0;
         remaining <= '0;
      end else if (load) begin
         bank      <= ld_bank;
         row       <= ld_row;
         col       <= ld_col;
         remaining <= ld_len;
      end else if (step) begin
         col       <= col_sum[COL_W-1:0];
         remaining <= remaining - LEN_W'(1);
         if (col_wrap) begin
            row <= row + ROW_W'(1);
         end
      end
   end

endmodule

// File: rtl/sdram_wr_burst.sv
// rtl/sdram_wr_burst.sv - multi-burst SDRAM write engine with row crossing and refresh yield
module sdram_wr_burst
   import sdram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ROW_W  = 13,
   parameter int COL_W  = 9,
   parameter int BANK_W = 2,
   parameter int BL     = 4,
   parameter int LEN_W  = 16,
   parameter int T_RCD  = 3,
   parameter int T_RP   = 3,
   parameter int T_WR   = 2
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              wr_trig,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [COL_W-1:0]  wr_col,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic              wr_en,
   input  logic              ref_req,
   output logic              wr_req,
   output logic              flag_wr_end,
   output logic              wr_done,
   output logic              busy,
   output logic              fifo_rd,
   input  logic [DATA_W-1:0] fifo_data,
   output logic [3:0]        wr_cmd,
   output logic [ROW_W-1:0]  wr_addr,
   output logic [BANK_W-1:0] bank_addr,
   output logic [DATA_W-1:0] wr_data
);

   // Terminal values of the shared cycle counter in each timed state
   localparam logic [7:0] CNT_RCD  = 8'(T_RCD);
   localparam logic [7:0] CNT_BEAT = 8'(BL - 1);
   localparam logic [7:0] CNT_WR   = 8'((T_WR > 0) ? (T_WR - 1) : 0);
   localparam logic [7:0] CNT_RP   = 8'(T_RP);

   wr_state_t state, state_nxt;
   wr_exit_t  exit_sel, exit_nxt;
   logic [7:0] cnt, cnt_nxt;

   logic              ag_load, ag_step;
   logic [BANK_W-1:0] ag_bank;
   logic [ROW_W-1:0]  ag_row;
   logic [COL_W-1:0]  ag_col;
   logic              col_wrap, last_burst;

   logic [3:0]        cmd_nxt;
   logic [ROW_W-1:0]  addr_nxt;
   logic [BANK_W-1:0] bank_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [ROW_W-1:0]  col_addr, pre_addr;

   sdram_wr_addr_gen #(
      .ROW_W  (ROW_W),
      .COL_W  (COL_W),
      .BANK_W (BANK_W),
      .BL     (BL),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .sclk       (sclk),
      .reset      (reset),
      .load       (ag_load),
      .ld_bank    (wr_bank),
      .ld_row     (wr_row),
      .ld_col     (wr_col),
      .ld_len     (wr_len),
      .step       (ag_step),
      .bank       (ag_bank),
      .row        (ag_row),
      .col        (ag_col),
      .col_wrap   (col_wrap),
      .last_burst (last_burst)
   );

   // Column address with A10 forced low, precharge address with only A10 set
   always_comb begin
      col_addr              = '0;
      col_addr[COL_W-1:0]   = ag_col;
      col_addr[A10_BIT]     = 1'b0;
      pre_addr              = '0;
      pre_addr[A10_BIT]     = 1'b1;
   end

   // Status and strobes decode straight from the registered state
   assign wr_req      = (state == ST_REQ);
   assign busy        = (state != ST_IDLE);
   assign fifo_rd     = (state == ST_WR);
   assign flag_wr_end = (state == ST_PRE) && (cnt == CNT_RP) && (exit_sel != EXIT_ACT);
   assign wr_done     = (state == ST_PRE) && (cnt == CNT_RP) && (exit_sel == EXIT_IDLE);

   // State, counter and registered bus outputs
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         exit_sel  <= EXIT_IDLE;
         cnt       <= '0;
         wr_cmd    <= CMD_NOP;
         wr_addr   <= '0;
         bank_addr <= '0;
         wr_data   <= '0;
      end else begin
         state     <= state_nxt;
         exit_sel  <= exit_nxt;
         cnt       <= cnt_nxt;
         wr_cmd    <= cmd_nxt;
         wr_addr   <= addr_nxt;
         bank_addr <= bank_nxt;
         wr_data   <= data_nxt;
      end
   end

   // Next state, counter and the command/address/data to present next cycle
   always_comb begin
      state_nxt = state;
      exit_nxt  = exit_sel;
      cnt_nxt   = cnt;
      ag_load   = 1'b0;
      ag_step   = 1'b0;
      cmd_nxt   = CMD_NOP;
      addr_nxt  = wr_addr;
      bank_nxt  = bank_addr;
      data_nxt  = wr_data;

      case (state)
         ST_IDLE: begin
            if (wr_trig && (wr_len != '0)) begin
               ag_load   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_REQ;
            end
         end

         ST_REQ: begin
            if (wr_en) begin
               cnt_nxt   = '0;
               state_nxt = ST_ACT;
            end
         end

         ST_ACT: begin
            if (cnt == '0) begin
               cmd_nxt  = CMD_ACT;
               addr_nxt = ag_row;
               bank_nxt = ag_bank;
            end
            if (cnt == CNT_RCD) begin
               cnt_nxt   = '0;
               state_nxt = ST_WR;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end

         ST_WR: begin
            data_nxt = fifo_data;
            if (cnt == '0) begin
               cmd_nxt  = CMD_WR;
               addr_nxt = col_addr;
               bank_nxt = ag_bank;
            end
            if (cnt == CNT_BEAT) begin
               // Burst boundary: completion beats refresh, refresh beats row crossing
               ag_step = 1'b1;
               cnt_nxt = '0;
               if (last_burst) begin
                  exit_nxt  = EXIT_IDLE;
                  state_nxt = ST_RECOV;
               end else if (ref_req) begin
                  exit_nxt  = EXIT_REQ;
                  state_nxt = ST_RECOV;
               end else if (col_wrap) begin
                  exit_nxt  = EXIT_ACT;
                  state_nxt = ST_RECOV;
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end

         ST_RECOV: begin
            if (cnt == CNT_WR) begin
               cnt_nxt   = '0;
               state_nxt = ST_PRE;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end

         ST_PRE: begin
            if (cnt == '0) begin
               cmd_nxt  = CMD_PRE;
               addr_nxt = pre_addr;
            end
            if (cnt == CNT_RP) begin
               cnt_nxt = '0;
               case (exit_sel)
                  EXIT_REQ: state_nxt = ST_REQ;
                  EXIT_ACT: state_nxt = ST_ACT;
                  default:  state_nxt = ST_IDLE;
               endcase
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// tb/tb_sdram_wr_burst.sv - scoreboard bench for the SDRAM write burst engine
module tb_sdram_wr_burst;
   import sdram_pkg::*;

   localparam int DATA_W = 16;
   localparam int ROW_W  = 13;
   localparam int COL_W  = 9;
   localparam int BANK_W = 2;
   localparam int BL     = 4;
   localparam int LEN_W  = 16;
   localparam int T_RCD  = 3;
   localparam int T_RP   = 3;
   localparam int T_WR   = 2;

   logic              sclk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_trig = 1'b0;
   logic [BANK_W-1:0] wr_bank = '0;
   logic [ROW_W-1:0]  wr_row = '0;
   logic [COL_W-1:0]  wr_col = '0;
   logic [LEN_W-1:0]  wr_len = '0;
   logic              wr_en = 1'b0;
   logic              ref_req = 1'b0;
   logic              wr_req, flag_wr_end, wr_done, busy, fifo_rd;
   logic [DATA_W-1:0] fifo_data;
   logic [3:0]        wr_cmd;
   logic [ROW_W-1:0]  wr_addr;
   logic [BANK_W-1:0] bank_addr;
   logic [DATA_W-1:0] wr_data;

   sdram_wr_burst #(
      .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .BL(BL),
      .LEN_W(LEN_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_WR(T_WR)
   ) dut (
      .sclk(sclk), .reset(reset), .wr_trig(wr_trig), .wr_bank(wr_bank), .wr_row(wr_row),
      .wr_col(wr_col), .wr_len(wr_len), .wr_en(wr_en), .ref_req(ref_req), .wr_req(wr_req),
      .flag_wr_end(flag_wr_end), .wr_done(wr_done), .busy(busy), .fifo_rd(fifo_rd),
      .fifo_data(fifo_data), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .bank_addr(bank_addr),
      .wr_data(wr_data)
   );

   always #5 sclk = ~sclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Show-ahead FIFO: word content is a function of its position
   logic [15:0] rd_ptr = '0;
   function automatic logic [15:0] fifo_word(input logic [15:0] p);
      return {4'hD, p[11:0]};
   endfunction
   assign fifo_data = fifo_word(rd_ptr);
   always @(posedge sclk) if (fifo_rd) rd_ptr <= rd_ptr + 16'd1;

   typedef struct {
      logic [3:0] cmd;
      int addr;
      int bank;
      int gap;
   } exp_t;
   exp_t        exp_q[$];
   logic [15:0] dat_q[$];

   int cyc = 0, last_cyc = 0, beats_left = 0;
   int pops = 0, flag_cnt = 0, done_cnt = 0, exp_flags = 0;
   always @(posedge sclk) cyc++;

   // Bus monitor: every non-NOP command and every data beat is checked against the queues
   always @(negedge sclk) begin
      exp_t e;
      if (reset) begin
         beats_left = 0;
      end else begin
         if (fifo_rd) pops++;
         if (flag_wr_end) flag_cnt++;
         if (wr_done) begin
            done_cnt++;
            chk("done_with_flag", flag_wr_end, 1);
         end
         if (wr_cmd == CMD_WR) beats_left = BL;
         if (beats_left > 0) begin
            if (dat_q.size() == 0) chk("data_extra", wr_data, 32'hFFFF_FFFF);
            else chk("wr_data", wr_data, dat_q.pop_front());
            beats_left--;
         end
         if (wr_cmd != CMD_NOP) begin
            if (exp_q.size() == 0) begin
               chk("cmd_extra", wr_cmd, CMD_NOP);
            end else begin
               e = exp_q.pop_front();
               chk("cmd", wr_cmd, e.cmd);
               chk("addr", wr_addr, e.addr);
               if (e.bank >= 0) chk("bank", bank_addr, e.bank);
               if (e.gap >= 0) chk("gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
         end
      end
   end

   // Arbiter model: grant two cycles after the request appears
   initial begin
      int gcnt = 0;
      forever begin
         @(negedge sclk);
         if (wr_req) begin
            gcnt++;
            wr_en = (gcnt >= 2);
         end else begin
            gcnt  = 0;
            wr_en = 1'b0;
         end
      end
   end

   // Expected command/data stream for one transfer; yield_k is the burst after which refresh wins
   task automatic build(input int bank, input int row, input int col, input int len, input int yield_k);
      int need_act = 1, act_gap = -1, wr_gap = -1;
      bit wrapped;
      for (int i = 0; i < len * BL; i++) dat_q.push_back(fifo_word(rd_ptr + 16'(i)));
      exp_flags = 1;
      for (int k = 0; k < len; k++) begin
         if (need_act) begin
            exp_q.push_back('{CMD_ACT, row, bank, act_gap});
            need_act = 0;
            wr_gap   = T_RCD + 1;
         end
         exp_q.push_back('{CMD_WR, col, bank, wr_gap});
         wr_gap  = BL;
         col     = (col + BL) % (1 << COL_W);
         wrapped = (col == 0);
         if (wrapped) row = (row + 1) % (1 << ROW_W);
         if (k == len - 1) begin
            exp_q.push_back('{CMD_PRE, 'h400, -1, BL + T_WR});
         end else if (k == yield_k) begin
            exp_q.push_back('{CMD_PRE, 'h400, -1, BL + T_WR});
            need_act = 1;
            act_gap  = -1;
            exp_flags++;
         end else if (wrapped) begin
            exp_q.push_back('{CMD_PRE, 'h400, -1, BL + T_WR});
            need_act = 1;
            act_gap  = T_RP + 1;
         end
      end
   endtask

   task automatic trig(input int bank, input int row, input int col, input int len);
      @(negedge sclk);
      wr_bank = BANK_W'(bank);
      wr_row  = ROW_W'(row);
      wr_col  = COL_W'(col);
      wr_len  = LEN_W'(len);
      wr_trig = 1'b1;
      @(negedge sclk);
      wr_trig = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin
         @(posedge sclk);
         n++;
      end
      if (done_cnt == start) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_wr_at(input string tag, input int col);
      int n = 0;
      do begin
         @(negedge sclk);
         n++;
      end while (!(wr_cmd == CMD_WR && wr_addr == ROW_W'(col)) && n < 300);
      if (n >= 300) chk({tag, "_wr_timeout"}, 0, 1);
   endtask

   task automatic run_end(input string tag, input int len, input int flag0, input int done0);
      repeat (3) @(negedge sclk);
      chk({tag, "_q_empty"}, exp_q.size(), 0);
      chk({tag, "_data_empty"}, dat_q.size(), 0);
      chk({tag, "_pops"}, pops, len * BL);
      chk({tag, "_flags"}, flag_cnt - flag0, exp_flags);
      chk({tag, "_done"}, done_cnt - done0, 1);
      chk({tag, "_idle"}, busy, 0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int hits = 0;
      repeat (cycles) begin
         @(negedge sclk);
         if (wr_req || busy) hits++;
      end
      chk({tag, "_no_req"}, hits, 0);
   endtask

   initial begin
      int f0, d0, n;
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, d0, n;
      // Reset values
      @(negedge sclk);
      chk("rst_cmd", wr_cmd, CMD_NOP);
      chk("rst_addr", wr_addr, 0);
      chk("rst_bank", bank_addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", wr_req, 0);
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_pulses", {flag_wr_end, wr_done}, 0);
      @(negedge sclk);
      reset = 1'b0;

      // 1: single burst
      f0 = flag_cnt; d0 = done_cnt; pops = 0;
      build(1, 5, 8, 1, -1);
      trig(1, 5, 8, 1);
      wait_done("t1", 200);
      run_end("t1", 1, f0, d0);

      // 2: back-to-back bursts in one row
      f0 = flag_cnt; d0 = done_cnt; pops = 0;
      build(0, 20, 0, 3, -1);
      trig(0, 20, 0, 3);
      wait_done("t2", 300);
      run_end("t2", 3, f0, d0);

      // 3: row crossing
      f0 = flag_cnt; d0 = done_cnt; pops = 0;
      build(2, 7, 504, 3, -1);
      trig(2, 7, 504, 3);
      wait_done("t3", 300);
      run_end("t3", 3, f0, d0);

      // 4: refresh pre-emption during burst at col 4, resume at col 8
      f0 = flag_cnt; d0 = done_cnt; pops = 0;
      build(2, 10, 0, 4, 1);
      trig(2, 10, 0, 4);
      wait_wr_at("t4", 4);
      ref_req = 1'b1;
      n = 0;
      while (!wr_req && n < 100) begin
         @(negedge sclk);
         n++;
      end
      chk("t4_yield_req", wr_req, 1);
      chk("t4_no_done_on_yield", done_cnt - d0, 0);
      chk("t4_flag_on_yield", flag_cnt - f0, 1);
      ref_req = 1'b0;
      wait_done("t4", 400);
      run_end("t4", 4, f0, d0);

      // 5: refresh at the last beat of the last burst takes the completion path
      f0 = flag_cnt; d0 = done_cnt; pops = 0;
      build(3, 100, 32, 2, -1);
      trig(3, 100, 32, 2);
      wait_wr_at("t5", 36);
      ref_req = 1'b1;
      wait_done("t5", 200);
      run_end("t5", 2, f0, d0);
      quiet("t5", 10);
      ref_req = 1'b0;

      // 6: asynchronous reset mid-WR
      build(1, 3, 0, 4, -1);
      trig(1, 3, 0, 4);
      wait_wr_at("t6", 0);
      #2 reset = 1'b1;
      #1;
      chk("t6_cmd", wr_cmd, CMD_NOP);
      chk("t6_addr", wr_addr, 0);
      chk("t6_bank", bank_addr, 0);
      chk("t6_data", wr_data, 0);
      chk("t6_busy", busy, 0);
      chk("t6_fifo_rd", fifo_rd, 0);
      exp_q.delete();
      dat_q.delete();
      repeat (2) @(negedge sclk);
      reset = 1'b0;

      // zero-length trigger is ignored
      trig(0, 1, 0, 0);
      quiet("t6_len0", 10);

      // trigger while busy is ignored
      f0 = flag_cnt; d0 = done_cnt; pops = 0;
      build(2, 2, 16, 1, -1);
      trig(2, 2, 16, 1);
      trig(3, 9, 40, 2);
      wait_done("t6b", 200);
      run_end("t6b", 1, f0, d0);
      quiet("t6b", 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
